// File: rtl/lsu.sv
// Load/store unit: takes one RV32I load or store from the core, runs a single word-aligned
// memory transaction with byte strobes and a timeout, then reports sign/zero-extended data or a fault.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err_misaligned,
  output logic        err_access
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] cnt_q, cnt_d, rdata_q, rdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        store_q, store_d, err_mis_q, err_mis_d, err_acc_q, err_acc_d;
  logic        illegal, misaligned;
  logic [31:0] lane, load_val, cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      funct3_q  <= '0;
      store_q   <= 1'b0;
      err_mis_q <= 1'b0;
      err_acc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      funct3_q  <= funct3_d;
      store_q   <= store_d;
      err_mis_q <= err_mis_d;
      err_acc_q <= err_acc_d;
    end
  end

  // Illegal encodings take precedence over alignment faults.
  always_comb begin
    illegal = (req_load == req_store)
           || (req_load && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7))
           || (req_store && funct3 >= 3'd3);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0])
              || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  always_comb begin
    lane    = mem_rdata >> {addr_q[1:0], 3'b000};
    cnt_inc = cnt_q + 32'd1;
    case (funct3_q)
      3'd0:    load_val = {{24{lane[7]}}, lane[7:0]};
      3'd1:    load_val = {{16{lane[15]}}, lane[15:0]};
      3'd4:    load_val = {24'd0, lane[7:0]};
      3'd5:    load_val = {16'd0, lane[15:0]};
      default: load_val = lane;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    funct3_d  = funct3_q;
    store_d   = store_q;
    err_mis_d = err_mis_q;
    err_acc_d = err_acc_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d    = addr;
          wdata_d   = wdata;
          funct3_d  = funct3;
          store_d   = req_store;
          cnt_d     = '0;
          rdata_d   = '0;
          err_mis_d = 1'b0;
          err_acc_d = 1'b0;
          if (illegal) begin
            err_acc_d = 1'b1;
            state_d   = DONE;
          end else if (misaligned) begin
            err_mis_d = 1'b1;
            state_d   = DONE;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // A response arriving in the final timeout cycle still wins.
        if (mem_ready) begin
          rdata_d = store_q ? 32'd0 : load_val;
          state_d = DONE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_inc == TIMEOUT_CYCLES) begin
          err_acc_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready      = (state_q == IDLE);
    mem_valid      = (state_q == ACCESS);
    done           = (state_q == DONE);
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_wstrb      = '0;
    rdata          = done ? rdata_q : 32'd0;
    err_misaligned = done & err_mis_q;
    err_access     = done & err_acc_q;
    if (mem_valid) begin
      mem_we   = store_q;
      mem_addr = {addr_q[31:2], 2'b00};
      if (store_q) begin
        case (funct3_q[1:0])
          2'b00: begin
            mem_wstrb = 4'b0001 << addr_q[1:0];
            mem_wdata = {4{wdata_q[7:0]}};
          end
          2'b01: begin
            mem_wstrb = 4'b0011 << addr_q[1:0];
            mem_wdata = {2{wdata_q[15:0]}};
          end
          default: begin
            mem_wstrb = 4'b1111;
            mem_wdata = wdata_q;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu, built with a short timeout so the
// timeout path and its priority against mem_ready can be exercised quickly.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, req_load, req_store;
  logic [31:0] addr, wdata, mem_addr, mem_wdata, mem_rdata, rdata;
  logic [2:0]  funct3;
  logic        mem_valid, mem_ready, mem_we, done, err_misaligned, err_access;
  logic [3:0]  mem_wstrb;

  int numChecks = 0;
  int numFail   = 0;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_load(req_load), .req_store(req_store), .addr(addr), .wdata(wdata),
    .funct3(funct3), .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .done(done), .rdata(rdata),
    .err_misaligned(err_misaligned), .err_access(err_access)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numChecks++;
    assert (observed === expected) else begin
      numFail++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single edge, then withdraws it.
  task automatic applyStimulus(input logic ld, input logic st, input logic [31:0] a,
                               input logic [31:0] wd, input logic [2:0] f3);
    req_valid = 1'b1;
    req_load  = ld;
    req_store = st;
    addr      = a;
    wdata     = wd;
    funct3    = f3;
    tick();
    req_valid = 1'b0;
    req_load  = 1'b0;
    req_store = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_rdata"}, rdata, 32'd0);
    checkOutput({tag, "_err_mis"}, 32'(err_misaligned), 32'd0);
    checkOutput({tag, "_err_acc"}, 32'(err_access), 32'd0);
  endtask

  // Load that completes after one ACCESS cycle.
  task automatic runLoad(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] word, input logic [31:0] expAddr, input logic [31:0] expData);
    applyStimulus(1'b1, 1'b0, a, 32'd0, f3);
    checkOutput({tag, "_mem_addr"}, mem_addr, expAddr);
    mem_rdata = word;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_rdata"}, rdata, expData);
    checkOutput({tag, "_errs"}, {30'd0, err_misaligned, err_access}, 32'd0);
    tick();
  endtask

  // Request that must fault in IDLE and finish the very next cycle.
  task automatic runFault(input string tag, input logic ld, input logic st, input logic [31:0] a,
                          input logic [2:0] f3, input logic expMis, input logic expAcc);
    applyStimulus(ld, st, a, 32'hFFFF_FFFF, f3);
    checkOutput({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd1);
    checkOutput({tag, "_errs"}, {30'd0, err_misaligned, err_access}, {30'd0, expMis, expAcc});
    checkOutput({tag, "_rdata"}, rdata, 32'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0;
    addr = '0; wdata = '0; funct3 = '0; mem_ready = 1'b0; mem_rdata = '0;
    tick();
    tick();
    rst = 1'b0;
    checkIdleOutputs("reset");

    // LB from the top byte lane, memory answers in the third ACCESS cycle.
    applyStimulus(1'b1, 1'b0, 32'h0000_1003, 32'd0, 3'd0);
    mem_rdata = 32'h80FF_1234;
    checkOutput("lb_mem_valid", 32'(mem_valid), 32'd1);
    checkOutput("lb_mem_addr", mem_addr, 32'h0000_1000);
    checkOutput("lb_mem_we", 32'(mem_we), 32'd0);
    checkOutput("lb_wstrb", 32'(mem_wstrb), 32'd0);
    checkOutput("lb_req_ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    checkOutput("lb_hold_valid", 32'(mem_valid), 32'd1);
    checkOutput("lb_hold_done", 32'(done), 32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checkOutput("lb_done", 32'(done), 32'd1);
    checkOutput("lb_rdata", rdata, 32'hFFFF_FF80);
    checkOutput("lb_valid_drop", 32'(mem_valid), 32'd0);
    tick();
    checkOutput("lb_done_once", 32'(done), 32'd0);
    checkOutput("lb_back_idle", 32'(req_ready), 32'd1);

    // SH to the upper half with mem_ready already high while idle.
    mem_ready = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'h0000_2002, 32'h0000_ABCD, 3'd1);
    checkOutput("sh_wstrb", 32'(mem_wstrb), 32'h0000_000C);
    checkOutput("sh_wdata", mem_wdata, 32'hABCD_ABCD);
    checkOutput("sh_we", 32'(mem_we), 32'd1);
    checkOutput("sh_addr", mem_addr, 32'h0000_2000);
    tick();
    mem_ready = 1'b0;
    checkOutput("sh_done", 32'(done), 32'd1);
    checkOutput("sh_rdata", rdata, 32'd0);
    checkOutput("sh_errs", {30'd0, err_misaligned, err_access}, 32'd0);
    tick();

    // SB into lane 1 and SW.
    applyStimulus(1'b0, 1'b1, 32'h0000_0011, 32'h1234_565A, 3'd0);
    checkOutput("sb_wstrb", 32'(mem_wstrb), 32'h0000_0002);
    checkOutput("sb_wdata", mem_wdata, 32'h5A5A_5A5A);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checkOutput("sb_done", 32'(done), 32'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_0044, 32'hCAFE_F00D, 3'd2);
    checkOutput("sw_wstrb", 32'(mem_wstrb), 32'h0000_000F);
    checkOutput("sw_wdata", mem_wdata, 32'hCAFE_F00D);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checkOutput("sw_done", 32'(done), 32'd1);
    tick();

    runLoad("lh",  32'h0000_0102, 3'd1, 32'h8001_7FFF, 32'h0000_0100, 32'hFFFF_8001);
    runLoad("lhu", 32'h0000_0102, 3'd5, 32'h8001_7FFF, 32'h0000_0100, 32'h0000_8001);
    runLoad("lh0", 32'h0000_0100, 3'd1, 32'h8001_7FFF, 32'h0000_0100, 32'h0000_7FFF);
    runLoad("lbu", 32'h0000_0201, 3'd4, 32'h0000_F200, 32'h0000_0200, 32'h0000_00F2);
    runLoad("lw",  32'h0000_0040, 3'd2, 32'hDEAD_BEEF, 32'h0000_0040, 32'hDEAD_BEEF);

    runFault("lw_mis",   1'b1, 1'b0, 32'h0000_3001, 3'd2, 1'b1, 1'b0);
    runFault("sh_mis",   1'b0, 1'b1, 32'h0000_3003, 3'd1, 1'b1, 1'b0);
    runFault("both_ill", 1'b1, 1'b1, 32'h0000_3000, 3'd2, 1'b0, 1'b1);
    runFault("none_ill", 1'b0, 1'b0, 32'h0000_3000, 3'd2, 1'b0, 1'b1);
    runFault("ld_f3_3",  1'b1, 1'b0, 32'h0000_3000, 3'd3, 1'b0, 1'b1);
    runFault("st_f3_3",  1'b0, 1'b1, 32'h0000_3001, 3'd3, 1'b0, 1'b1);

    // LHU with no response: four ACCESS cycles, then timeout.
    applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'd0, 3'd5);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("to_valid_%0d", i), 32'(mem_valid), 32'd1);
      tick();
    end
    checkOutput("to_valid_drop", 32'(mem_valid), 32'd0);
    checkOutput("to_done", 32'(done), 32'd1);
    checkOutput("to_err_acc", 32'(err_access), 32'd1);
    checkOutput("to_err_mis", 32'(err_misaligned), 32'd0);
    checkOutput("to_rdata", rdata, 32'd0);
    tick();

    // Response in the final timeout cycle completes normally.
    applyStimulus(1'b1, 1'b0, 32'h0000_0500, 32'd0, 3'd2);
    tick();
    tick();
    tick();
    mem_rdata = 32'h0BAD_F00D;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checkOutput("tolast_done", 32'(done), 32'd1);
    checkOutput("tolast_err", {30'd0, err_misaligned, err_access}, 32'd0);
    checkOutput("tolast_rdata", rdata, 32'h0BAD_F00D);
    tick();

    // Reset during the second ACCESS cycle, then a stray mem_ready.
    applyStimulus(1'b1, 1'b0, 32'h0000_0600, 32'd0, 3'd2);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    checkIdleOutputs("midrst");
    tick();
    checkOutput("midrst_no_done", 32'(done), 32'd0);
    runLoad("post_rst", 32'h0000_0050, 3'd2, 32'h1357_9BDF, 32'h0000_0050, 32'h1357_9BDF);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFail);
    $finish;
  end

endmodule
